// File: rtl/mem_flush_seq.sv
// Memory-maintenance sequencer: FENCE.I / SFENCE.VMA / abort -> drain, clear, sync, TLB flush, done.
// Optional watchdog on the DRAIN/SYNC waits is compiled in with `define FLUSH_SEQ_WATCHDOG_EN.
package mem_flush_seq_pkg;
    typedef enum logic [1:0] {
        NoFlush   = 2'd0,
        FlushAll  = 2'd1,
        FlushASID = 2'd2,
        FlushPage = 2'd3
    } tlb_flush_type_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        CLR   = 3'd2,
        SYNC  = 3'd3,
        TLBF  = 3'd4,
        DONE  = 3'd5
    } flush_state_t;

    localparam logic [1:0] REQ_FENCE_I = 2'd0;
    localparam logic [1:0] REQ_SFENCE  = 2'd1;
    localparam logic [1:0] REQ_ABORT   = 2'd2;
endpackage

// Handshake: a request transfers on any clock edge where req_valid_i && req_ready_o;
// req_ready_o is high only in IDLE, so req_valid_i is ignored while a sequence runs.
module mem_flush_seq
    import mem_flush_seq_pkg::*;
#(
    parameter int unsigned ASID_LEN = 16,
    parameter int unsigned VPN_LEN  = 27,
    parameter int unsigned WDOG_CYC = 255
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_type_i,
    input  logic                req_asid_valid_i,
    input  logic                req_vpn_valid_i,
    input  logic [ASID_LEN-1:0] req_asid_i,
    input  logic [VPN_LEN-1:0]  req_vpn_i,
    input  logic                pipe_empty_i,
    input  logic                l2c_update_done_i,
    output logic                stall_o,
    output logic                clr_l1tlb_mshr_o,
    output logic                clr_l2tlb_mshr_o,
    output logic                clear_dmshr_dregs_o,
    output logic                synch_l1dc_l2c_o,
    output tlb_flush_type_t     l1tlb_flush_type_o,
    output tlb_flush_type_t     l2tlb_flush_type_o,
    output logic [ASID_LEN-1:0] flush_asid_o,
    output logic [VPN_LEN-1:0]  flush_page_o,
    output logic                done_o,
    output logic                timeout_o,
    output flush_state_t        dbg_state_o
);

    flush_state_t        state_q, state_d;
    logic [1:0]          type_q;
    logic                asid_valid_q, vpn_valid_q;
    logic [ASID_LEN-1:0] asid_q;
    logic [VPN_LEN-1:0]  vpn_q;
    logic                accept;
    logic                wdog_expire;
    tlb_flush_type_t     tlb_cmd;

    assign accept      = (state_q == IDLE) && req_valid_i;
    assign dbg_state_o = state_q;

`ifdef FLUSH_SEQ_WATCHDOG_EN
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYC - 1);
    logic [7:0] wdog_cnt_q;
    logic       timeout_q;
    logic       wait_exit;

    assign wait_exit   = ((state_q == DRAIN) && pipe_empty_i) ||
                         ((state_q == SYNC) && l2c_update_done_i);
    assign wdog_expire = ((state_q == DRAIN) || (state_q == SYNC)) &&
                         (wdog_cnt_q == WDOG_LAST) && !wait_exit;

    // Counter restarts on every state change, so it is zero in the first DRAIN/SYNC cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= wdog_expire;
            if (state_q != state_d) wdog_cnt_q <= '0;
            else if ((state_q == DRAIN) || (state_q == SYNC)) wdog_cnt_q <= wdog_cnt_q + 8'd1;
        end
    end
    assign timeout_o = timeout_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYC;
    assign wdog_expire = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Reserved type 3 is folded into ABORT at latch time.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            type_q       <= REQ_FENCE_I;
            asid_valid_q <= 1'b0;
            vpn_valid_q  <= 1'b0;
            asid_q       <= '0;
            vpn_q        <= '0;
        end else if (accept) begin
            type_q       <= (req_type_i == 2'd3) ? REQ_ABORT : req_type_i;
            asid_valid_q <= req_asid_valid_i;
            vpn_valid_q  <= req_vpn_valid_i;
            asid_q       <= req_asid_i;
            vpn_q        <= req_vpn_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid_i)
                       state_d = ((req_type_i == REQ_FENCE_I) || (req_type_i == REQ_SFENCE)) ? DRAIN : CLR;
            DRAIN: if (pipe_empty_i || wdog_expire) state_d = CLR;
            CLR:   state_d = (type_q == REQ_ABORT) ? DONE : SYNC;
            SYNC:  if (l2c_update_done_i || wdog_expire)
                       state_d = (type_q == REQ_SFENCE) ? TLBF : DONE;
            TLBF:  state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (vpn_valid_q)       tlb_cmd = FlushPage;
        else if (asid_valid_q) tlb_cmd = FlushASID;
        else                   tlb_cmd = FlushAll;
    end

    always_comb begin
        req_ready_o         = (state_q == IDLE);
        stall_o             = (state_q != IDLE);
        clr_l1tlb_mshr_o    = 1'b0;
        clr_l2tlb_mshr_o    = 1'b0;
        clear_dmshr_dregs_o = 1'b0;
        synch_l1dc_l2c_o    = 1'b0;
        l1tlb_flush_type_o  = NoFlush;
        l2tlb_flush_type_o  = NoFlush;
        flush_asid_o        = '0;
        flush_page_o        = '0;
        done_o              = 1'b0;
        case (state_q)
            CLR: begin
                clear_dmshr_dregs_o = 1'b1;
                clr_l1tlb_mshr_o    = (type_q != REQ_FENCE_I);
                clr_l2tlb_mshr_o    = (type_q != REQ_FENCE_I);
            end
            SYNC: synch_l1dc_l2c_o = 1'b1;
            TLBF: begin
                l1tlb_flush_type_o = tlb_cmd;
                l2tlb_flush_type_o = tlb_cmd;
                flush_asid_o       = asid_valid_q ? asid_q : '0;
                flush_page_o       = vpn_valid_q ? vpn_q : '0;
            end
            DONE: done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mem_flush_seq.md
# mem_flush_seq

Sequencer that turns FENCE.I, SFENCE.VMA and exception-abort requests into an ordered series of memory-subsystem maintenance commands. It sits between the main control unit and the L1/L2 TLBs, the D-cache MSHR and the L1D→L2 synchroniser. It stalls the front end, then drains the pipeline, clears MSHRs, synchronises the caches, flushes the TLBs and reports completion.

## Interface
- ASID_LEN, 16, width of the address-space identifier
- VPN_LEN, 27, width of the virtual page number
- WDOG_CYC, 255, watchdog limit in cycles (used only with watchdog compiled in)

- clk_i  in  1  clock
- rst_n_i  in  1  reset: one clock; asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted (IDLE only)
- req_type_i  in  2  0 FENCE_I, 1 SFENCE_VMA, 2 ABORT, 3 reserved (treated as ABORT)
- req_asid_valid_i  in  1  SFENCE rs2≠x0
- req_vpn_valid_i  in  1  SFENCE rs1≠x0
- req_asid_i  in  ASID_LEN  SFENCE ASID
- req_vpn_i  in  VPN_LEN  SFENCE page
- pipe_empty_i  in  1  backend has no in-flight memory ops
- l2c_update_done_i  in  1  L1D→L2 writeback complete
- stall_o  out  1  front-end stall
- clr_l1tlb_mshr_o / clr_l2tlb_mshr_o / clear_dmshr_dregs_o  out  1 each  clear pulses
- synch_l1dc_l2c_o  out  1  synchronisation request (level)
- l1tlb_flush_type_o / l2tlb_flush_type_o  out  tlb_flush_type_t  TLB flush command
- flush_asid_o  out  ASID_LEN  flush ASID
- flush_page_o  out  VPN_LEN  flush VPN
- done_o  out  1  completion pulse
- timeout_o  out  1  watchdog expiry pulse

## Operation
- States: IDLE, DRAIN, CLR, SYNC, TLBF, DONE. All outputs are Moore outputs decoded from the registered state and the latched request.
- IDLE: req_ready_o=1. On req_valid_i, latch type, ASID, VPN and the valid flags. FENCE_I and SFENCE_VMA go to DRAIN; ABORT goes to CLR.
- DRAIN: stall_o=1. Move to CLR in the first cycle pipe_empty_i=1.
- CLR: one cycle.
  - FENCE_I pulses clear_dmshr_dregs_o.
  - SFENCE_VMA and ABORT pulse all three clear outputs.
  - Next state: SYNC for FENCE_I/SFENCE_VMA; DONE for ABORT.
- SYNC: synch_l1dc_l2c_o=1. Exit in the cycle l2c_update_done_i=1; the done input is sampled only in this state.
  - FENCE_I goes to DONE; SFENCE_VMA goes to TLBF.
- TLBF: one cycle. Both flush-type outputs carry the same value:
  - FlushPage if the VPN flag is set, with flush_page_o=VPN and flush_asid_o=ASID when the ASID flag is set, else 0.
  - Otherwise FlushASID if the ASID flag is set.
  - Otherwise FlushAll.
- DONE: done_o=1 for one cycle, then IDLE.
- stall_o=1 in every state except IDLE.
- Outside TLBF: flush types are NoFlush and flush_asid_o/flush_page_o are 0.
- req_valid_i is ignored outside IDLE. A new request can be accepted in the cycle after DONE.

## Timing
- Reset (asserted asynchronously at any point, including mid-sequence): state IDLE.
  - req_ready_o=1.
  - All other outputs 0, flush types NoFlush.
  - Latched request cleared.
  - No partial command is re-issued after reset.
- Best-case latency (inputs already high), counting the accept cycle as cycle 0:
  - SFENCE_VMA: done_o at cycle 5.
  - FENCE_I: done_o at cycle 4.
  - ABORT: done_o at cycle 2.
- Each extra cycle of pipe_empty_i=0 in DRAIN, or l2c_update_done_i=0 in SYNC, adds one cycle.
- Clear pulses and the TLBF command are exactly one cycle wide.

## Configuration
- FLUSH_SEQ_WATCHDOG_EN defined:
  - An 8-bit counter resets on entry to DRAIN and to SYNC, and increments each cycle spent waiting.
  - When it reaches WDOG_CYC, the FSM forces the normal next-state transition and pulses timeout_o for one cycle.
- FLUSH_SEQ_WATCHDOG_EN undefined:
  - No counter; DRAIN and SYNC wait indefinitely.
  - timeout_o is tied to 0.

## Test plan
- Reset during SYNC of an SFENCE → next edge: IDLE, req_ready_o=1, synch_l1dc_l2c_o=0, stall_o=0, done_o never pulses.
- SFENCE_VMA with vpn_valid=1, asid_valid=1, ASID=0x5, VPN=0x1234, pipe_empty_i and l2c_update_done_i tied high → done_o at cycle 5. In cycle 4: FlushPage, flush_page_o=0x1234, flush_asid_o=0x5.
- SFENCE with both flags 0 → FlushAll in TLBF. Same SFENCE with only asid_valid=1, ASID=0x7 → FlushASID with flush_asid_o=0x7.
- FENCE_I, pipe_empty_i low 3 cycles, l2c_update_done_i low 4 cycles → only clear_dmshr_dregs_o pulses; no TLB command; done_o at cycle 11.
- ABORT issued while pipe_empty_i=0 → no DRAIN wait; all three clear pulses at cycle 1; done_o at cycle 2. A second req_valid_i held during the sequence is accepted only in the cycle after DONE.
- Watchdog build, WDOG_CYC=10, l2c_update_done_i stuck low → timeout_o pulses once after 10 SYNC cycles, then TLBF and done_o follow. Non-watchdog build: the sequencer stays in SYNC indefinitely.
